// File: rtl/sm4_rk_sequencer_if.sv
// Bus between the SM4 round-key sequencer and the key-extension stage.
// master: sequencer side (issues round inputs, collects results).
// slave : extension-stage side.
interface sm4_rk_sequencer_if;
    logic [7:0]   o_ke_idx;
    logic [127:0] o_ke_key;
    logic         o_ke_valid;
    logic [31:0]  i_ke_rk;
    logic [127:0] i_ke_k;
    logic         i_ke_valid;

    modport master (
        output o_ke_idx, o_ke_key, o_ke_valid,
        input  i_ke_rk, i_ke_k, i_ke_valid
    );

    modport slave (
        input  o_ke_idx, o_ke_key, o_ke_valid,
        output i_ke_rk, i_ke_k, i_ke_valid
    );
endinterface

// File: rtl/sm4_rk_sequencer.sv
// SM4 round-key sequencer: walks the key-extension stage through rounds
// 0..31, captures rk0..rk31 in a local table and serves them through a
// registered read port in forward (encrypt) or reversed (decrypt) order.
// Optional build macro SM4_KEY_CACHE_EN: skip re-expansion when the same
// master key is offered again and the table already holds its schedule.
module sm4_rk_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [127:0]              i_key,
    input  logic                      i_key_valid,
    output logic                      o_key_ready,
    sm4_rk_sequencer_if.master        ke,
    input  logic [4:0]                i_rd_addr,
    input  logic                      i_rd_dec,
    output logic [31:0]               o_rd_rk,
    output logic                      o_rk_ready,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int unsigned NR    = 32;
    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       key_q, key_d;
    logic               ke_valid_q, ke_valid_d;
    logic               key_ready_q, key_ready_d;
    logic               busy_q, busy_d;
    logic               rk_ready_q, rk_ready_d;
    logic               err_q, err_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [31:0]        rd_rk_q, rd_rk_d;
    logic [IDX_W-1:0]   rd_phys;
    logic               tbl_we;
    logic               cache_hit;

    logic [31:0]        rk_tbl [NR];

`ifdef SM4_KEY_CACHE_EN
    logic [127:0]       cache_key_q, cache_key_d;
    logic               cache_vld_q, cache_vld_d;

    // Same key as the schedule already sitting in the table: nothing to do.
    assign cache_hit = cache_vld_q & rk_ready_q & (i_key == cache_key_q);
`else
    assign cache_hit = 1'b0;
`endif

    // Decrypt order reads the table back to front.
    assign rd_phys = i_rd_dec ? (LAST_IDX - i_rd_addr) : i_rd_addr;
    assign rd_rk_d = rk_tbl[rd_phys];

    // Next-state and register-input logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_d      = key_q;
        rk_ready_d = rk_ready_q;
        err_d      = err_q;
        to_d       = to_q;
        tbl_we     = 1'b0;
`ifdef SM4_KEY_CACHE_EN
        cache_key_d = cache_key_q;
        cache_vld_d = cache_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_key_valid && !cache_hit) begin
                    // Raw MK goes out; the stage folds in FK at index 0.
                    key_d      = i_key;
                    idx_d      = '0;
                    rk_ready_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = S_ISSUE;
`ifdef SM4_KEY_CACHE_EN
                    cache_key_d = i_key;
                    cache_vld_d = 1'b0;
`endif
                end
            end

            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (ke.i_ke_valid) begin
                    tbl_we = 1'b1;
                    key_d  = ke.i_ke_k;
                    // Next-state low word must be the round key just produced.
                    if (ke.i_ke_k[31:0] != ke.i_ke_rk) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_IDLE;
                        rk_ready_d = 1'b1;
`ifdef SM4_KEY_CACHE_EN
                        cache_vld_d = !err_d;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
`ifdef SM4_KEY_CACHE_EN
                    cache_vld_d = 1'b0;
`endif
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ke_valid_d  = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        key_ready_d = (state_d == S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            key_q       <= '0;
            ke_valid_q  <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rk_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            to_q        <= '0;
            rd_rk_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            key_q       <= key_d;
            ke_valid_q  <= ke_valid_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            rk_ready_q  <= rk_ready_d;
            err_q       <= err_d;
            to_q        <= to_d;
            rd_rk_q     <= rd_rk_d;
        end
    end

`ifdef SM4_KEY_CACHE_EN
    // Cached master key of the last clean expansion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

    // Round-key table; contents are only meaningful while o_rk_ready is high.
    always_ff @(posedge i_clk) begin
        if (tbl_we) begin
            rk_tbl[idx_q] <= ke.i_ke_rk;
        end
    end

    assign ke.o_ke_idx   = 8'(idx_q);
    assign ke.o_ke_key   = key_q;
    assign ke.o_ke_valid = ke_valid_q;
    assign o_key_ready   = key_ready_q;
    assign o_rd_rk       = rd_rk_q;
    assign o_rk_ready    = rk_ready_q;
    assign o_busy        = busy_q;
    assign o_err         = err_q;

endmodule
